// File: rtl/datapath_seq.sv
// ---------------------------------------------------------------------------
// datapath_seq
//
// Multi-cycle sequencer for the 8-bit register/bus datapath. It accepts
// 16-bit instructions over a valid/ready handshake and steps through one
// execute state per datapath action. It is the only block that drives the
// bus-mux select, the register write enables, the ALU strobes and the output
// handshake.
//
// Parameters:
//   ALU_TIMEOUT  ALU_WAIT cycles tolerated without alu_done before abort (1..255)
//   RET_W        width of the retired-instruction counter
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instr        instruction word: op=[15:12] rd=[11:9] rs=[8:6] imm=[7:0] func=[2:0]
//   instr_valid  instr is valid
//   instr_ready  sequencer accepts instr this cycle (FETCH only)
//   imm          immediate for the mux din input (LDI_WB only, else 0)
//   sel          bus-mux select: {r,2'b00} register r, 5'b00010 din, 5'b00001 ALU
//   reg_we       one-hot register write enable, bit = rd
//   alu_func     ALU function (ALU states only, else 0)
//   alu_lda      latch bus into ALU operand A
//   alu_ldb      latch bus into ALU operand B
//   alu_start    one-cycle ALU start pulse
//   alu_done     ALU result valid
//   out_valid    bus carries output data
//   out_ready    consumer takes output data
//   busy         instruction in progress
//   halted       HALT executed
//   err          sticky: illegal opcode or ALU timeout
//   retired      completed-instruction count, wraps
// ---------------------------------------------------------------------------
module datapath_seq #(
    parameter int ALU_TIMEOUT = 15,
    parameter int RET_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [7:0]       imm,
    output logic [4:0]       sel,
    output logic [7:0]       reg_we,
    output logic [2:0]       alu_func,
    output logic             alu_lda,
    output logic             alu_ldb,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [RET_W-1:0] retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_MOV_WB   = 4'd1;
    localparam logic [3:0] S_LDI_WB   = 4'd2;
    localparam logic [3:0] S_ALU_A    = 4'd3;
    localparam logic [3:0] S_ALU_B    = 4'd4;
    localparam logic [3:0] S_ALU_WAIT = 4'd5;
    localparam logic [3:0] S_ALU_WB   = 4'd6;
    localparam logic [3:0] S_OUT      = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ALU  = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    // The wait counter starts at 0 in the first ALU_WAIT cycle, so the abort
    // edge is the one where the count would step to ALU_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ALU_TIMEOUT - 1);

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [11:0] instr_q;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        retire;
    logic        set_err;

    logic [2:0]  rd_q;
    logic [2:0]  rs_q;
    logic [7:0]  imm_q;
    logic [2:0]  func_q;

    // Only the operand fields are kept; the opcode is fully consumed by the
    // FETCH decode and encoded in the next state.
    assign rd_q   = instr_q[11:9];
    assign rs_q   = instr_q[8:6];
    assign imm_q  = instr_q[7:0];
    assign func_q = instr_q[2:0];

    assign accept = instr_valid && (state == S_FETCH);

    // Next-state decode. retire and set_err are single-cycle pulses that the
    // status registers below fold into the counter and the sticky error.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_FETCH: begin
                if (instr_valid) begin
                    case (instr[15:12])
                        OP_NOP:  retire = 1'b1;
                        OP_MOV:  state_nxt = S_MOV_WB;
                        OP_LDI:  state_nxt = S_LDI_WB;
                        OP_ALU:  state_nxt = S_ALU_A;
                        OP_OUT:  state_nxt = S_OUT;
                        OP_HALT: begin
                            retire    = 1'b1;
                            state_nxt = S_HALT;
                        end
                        default: set_err = 1'b1;
                    endcase
                end
            end
            S_MOV_WB, S_LDI_WB, S_ALU_WB: begin
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ALU_A: state_nxt = S_ALU_B;
            S_ALU_B: state_nxt = S_ALU_WAIT;
            S_ALU_WAIT: begin
                // A done seen on the abort edge still wins over the timeout.
                if (alu_done) begin
                    state_nxt = S_ALU_WB;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction latch, loaded only on a handshake so the operand fields
    // stay stable for every execute state of that instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 12'h000;
        end else if (accept) begin
            instr_q <= instr[11:0];
        end
    end

    // ALU wait counter: held at zero outside ALU_WAIT, which clears it on
    // every entry into the wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'h00;
        end else if (state != S_ALU_WAIT) begin
            wait_cnt <= 8'h00;
        end else begin
            wait_cnt <= wait_cnt + 8'h01;
        end
    end

    // Status: sticky error and the free-wrapping retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            retired <= '0;
        end else begin
            if (set_err) begin
                err <= 1'b1;
            end
            if (retire) begin
                retired <= retired + RET_W'(1);
            end
        end
    end

    // Moore control outputs from state and the latched operand fields.
    // Everything defaults to the idle values so that asynchronous reset,
    // which forces FETCH, immediately restores the idle output set.
    always_comb begin
        instr_ready = 1'b0;
        imm         = 8'h00;
        sel         = 5'b00000;
        reg_we      = 8'h00;
        alu_func    = 3'b000;
        alu_lda     = 1'b0;
        alu_ldb     = 1'b0;
        alu_start   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
            end
            S_MOV_WB: begin
                sel          = {rs_q, 2'b00};
                reg_we[rd_q] = 1'b1;
            end
            S_LDI_WB: begin
                imm          = imm_q;
                sel          = 5'b00010;
                reg_we[rd_q] = 1'b1;
            end
            S_ALU_A: begin
                sel      = {rd_q, 2'b00};
                alu_lda  = 1'b1;
                alu_func = func_q;
            end
            S_ALU_B: begin
                sel       = {rs_q, 2'b00};
                alu_ldb   = 1'b1;
                alu_start = 1'b1;
                alu_func  = func_q;
            end
            S_ALU_WAIT: begin
                alu_func = func_q;
            end
            S_ALU_WB: begin
                sel          = 5'b00001;
                reg_we[rd_q] = 1'b1;
                alu_func     = func_q;
            end
            S_OUT: begin
                sel       = {rs_q, 2'b00};
                out_valid = 1'b1;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_seq.sv
// ---------------------------------------------------------------------------
// tb_datapath_seq
//
// Directed bench for datapath_seq. Inputs are driven and outputs sampled on
// the falling clock edge, so every check sees the state settled after the
// preceding rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_datapath_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  imm;
    logic [4:0]  sel;
    logic [7:0]  reg_we;
    logic [2:0]  alu_func;
    logic        alu_lda;
    logic        alu_ldb;
    logic        alu_start;
    logic        alu_done;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        halted;
    logic        err;
    logic [7:0]  retired;

    int checks = 0;
    int errors = 0;

    datapath_seq #(.ALU_TIMEOUT(15), .RET_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .imm         (imm),
        .sel         (sel),
        .reg_we      (reg_we),
        .alu_func    (alu_func),
        .alu_lda     (alu_lda),
        .alu_ldb     (alu_ldb),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word, input logic valid);
        instr       = word;
        instr_valid = valid;
    endtask

    // Presents one instruction for a single accept edge; returns at the
    // falling edge of the first cycle after the accept.
    task automatic issue(input logic [15:0] word);
        @(negedge clk);
        applyStimulus(word, 1'b1);
        @(negedge clk);
        applyStimulus(16'h0000, 1'b0);
    endtask

    // Checks the complete idle/reset output set.
    task automatic checkIdle(input string tag, input logic [7:0] exp_retired,
                             input logic exp_err);
        checkOutput({tag, "_sel"}, sel, 5'b00000);
        checkOutput({tag, "_imm_we_func"}, {imm, reg_we, alu_func}, 19'h0);
        checkOutput({tag, "_strobes"}, {alu_lda, alu_ldb, alu_start, out_valid}, 4'b0000);
        checkOutput({tag, "_rdy_busy_halt"}, {instr_ready, busy, halted}, 3'b100);
        checkOutput({tag, "_err"}, err, exp_err);
        checkOutput({tag, "_retired"}, retired, exp_retired);
    endtask

    initial begin
        int we_seen;
        int out_bad;
        rst_n     = 1'b0;
        alu_done  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(16'h0000, 1'b0);
        #12;
        checkIdle("reset", 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // MOV r3,r5 with valid held through the execute cycle.
        @(negedge clk);
        applyStimulus(16'h1740, 1'b1);
        @(negedge clk);
        checkOutput("mov_sel", sel, 5'b10100);
        checkOutput("mov_we", reg_we, 8'h08);
        checkOutput("mov_rdy_busy", {instr_ready, busy}, 2'b01);
        checkOutput("mov_ret_before", retired, 8'd0);
        @(negedge clk);
        applyStimulus(16'h0000, 1'b0);
        checkIdle("mov_after", 8'd1, 1'b0);

        // LDI r2,0xA5
        issue(16'h24A5);
        checkOutput("ldi_imm", imm, 8'hA5);
        checkOutput("ldi_sel", sel, 5'b00010);
        checkOutput("ldi_we", reg_we, 8'h04);
        @(negedge clk);
        checkIdle("ldi_after", 8'd2, 1'b0);

        // ALU r1 = r1 func3 r4, done in the third cycle after alu_start.
        issue(16'h3303);
        checkOutput("alua_sel", sel, 5'b00100);
        checkOutput("alua_strb", {alu_lda, alu_ldb, alu_start}, 3'b100);
        checkOutput("alua_func", alu_func, 3'd3);
        @(negedge clk);
        checkOutput("alub_sel", sel, 5'b10000);
        checkOutput("alub_strb", {alu_lda, alu_ldb, alu_start}, 3'b011);
        checkOutput("alub_func", alu_func, 3'd3);
        @(negedge clk);
        checkOutput("aluw1_func_we", {alu_func, reg_we}, {3'd3, 8'h00});
        checkOutput("aluw1_strb", {alu_lda, alu_ldb, alu_start}, 3'b000);
        @(negedge clk);
        checkOutput("aluw2_busy_we", {busy, reg_we}, {1'b1, 8'h00});
        @(negedge clk);
        alu_done = 1'b1;
        checkOutput("aluw3_we", reg_we, 8'h00);
        @(negedge clk);
        alu_done = 1'b0;
        checkOutput("aluwb_sel", sel, 5'b00001);
        checkOutput("aluwb_we", reg_we, 8'h02);
        checkOutput("aluwb_func", alu_func, 3'd3);
        @(negedge clk);
        checkIdle("alu_after", 8'd3, 1'b0);

        // OUT r7 with out_ready held low for four cycles.
        issue(16'h41C0);
        out_bad = 0;
        for (int i = 1; i <= 5; i++) begin
            if (out_valid !== 1'b1 || sel !== 5'b11100 || retired !== 8'd3)
                out_bad++;
            if (i == 5) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("out_stable", out_bad, 0);
        checkIdle("out_after", 8'd4, 1'b0);

        // Illegal opcode 0x5: sticky err, no retire, stays in FETCH.
        issue(16'h5000);
        checkIdle("illegal", 8'd4, 1'b1);

        // Fresh reset, then ALU timeout with alu_done never asserted.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkIdle("reset2", 8'd0, 1'b0);
        issue(16'h3303);
        @(negedge clk);
        we_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (reg_we !== 8'h00 || busy !== 1'b1 || err !== 1'b0) we_seen++;
        end
        checkOutput("tmo_wait15", we_seen, 0);
        @(negedge clk);
        checkIdle("tmo_after", 8'd0, 1'b1);

        // 256 back-to-back NOPs wrap the counter.
        applyStimulus(16'h0000, 1'b1);
        repeat (255) @(negedge clk);
        checkOutput("nop_255", retired, 8'd255);
        checkOutput("nop_rdy_busy", {instr_ready, busy}, 2'b10);
        @(negedge clk);
        applyStimulus(16'h0000, 1'b0);
        checkOutput("nop_wrap", retired, 8'd0);
        issue(16'h0000);
        checkOutput("nop_one", retired, 8'd1);

        // Reset asserted mid-ALU_WAIT, between clock edges.
        issue(16'h3303);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_busy", {busy, alu_func}, {1'b1, 3'd3});
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("rst_mid", 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // HALT is absorbing; further instructions are refused.
        issue(16'hF000);
        checkOutput("halt_state", {halted, instr_ready, busy}, 3'b100);
        checkOutput("halt_ret", retired, 8'd1);
        applyStimulus(16'h1740, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(16'h0000, 1'b0);
        checkOutput("halt_hold", {halted, instr_ready, busy}, 3'b100);
        checkOutput("halt_hold_we_ret", {reg_we, retired}, {8'h00, 8'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
